// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ sensor transmitter and its matching receiver.
// Holds the one-hot phase codes seen on the state port and the pixel LFSR
// seed, tap mask and step function.
package daq_pkg;

  typedef logic [7:0] pixel_t;

  // One-hot phase codes driven on the state port (all other phases read 000)
  localparam logic [2:0] ST_NONE  = 3'b000;
  localparam logic [2:0] ST_FOT   = 3'b001;
  localparam logic [2:0] ST_WR_EN = 3'b010;
  localparam logic [2:0] ST_ROT   = 3'b100;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3
  localparam pixel_t LFSR_SEED = 8'hA5;
  localparam pixel_t LFSR_TAPS = 8'hB8;

  function automatic pixel_t lfsr_next(input pixel_t s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/daq_sensor_tx_pattern.sv
// Pixel pattern generator for daq_sensor_tx. Inputs are the next-cycle
// strobes and counters from the top FSM; the pixel is registered here so it
// lines up with the other registered outputs.
// Build option: define DAQ_SENSOR_TX_LFSR_EN for an LFSR pattern, otherwise a
// (frame_cnt + row + col) ramp is produced.
module daq_sensor_tx_pattern
  import daq_pkg::*;
#(
  parameter int ROW_W = 1,
  parameter int COL_W = 1
) (
  input  logic             daq_clk,
  input  logic             sys_rst_n,
  input  logic             frame_start,
  input  logic             line_vld,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  logic [7:0]       frame_cnt,
  output logic [7:0]       pixel
);

  pixel_t pixel_q, pixel_d;

`ifdef DAQ_SENSOR_TX_LFSR_EN
  pixel_t lfsr_q, lfsr_d;
  logic   unused_pattern_in;

  assign unused_pattern_in = ^{row, col, frame_cnt};

  // LFSR reseeds on FOT entry and steps once per emitted pixel; the current
  // value is the pixel, so the first pixel of a frame is the seed
  always_comb begin
    lfsr_d  = lfsr_q;
    pixel_d = '0;
    if (frame_start) begin
      lfsr_d = LFSR_SEED;
    end else if (line_vld) begin
      lfsr_d  = lfsr_next(lfsr_q);
      pixel_d = lfsr_q;
    end
  end

  // LFSR state register
  always_ff @(posedge daq_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) lfsr_q <= LFSR_SEED;
    else            lfsr_q <= lfsr_d;
  end
`else
  logic unused_pattern_in;

  assign unused_pattern_in = frame_start;

  // Ramp pattern, 8-bit arithmetic gives the mod-256 wrap
  always_comb begin
    pixel_d = '0;
    if (line_vld) pixel_d = frame_cnt + 8'(row) + 8'(col);
  end
`endif

  // Registered pixel output, zero outside active lines
  always_ff @(posedge daq_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pixel_q <= '0;
    else            pixel_q <= pixel_d;
  end

  assign pixel = pixel_q;

endmodule

// File: rtl/daq_sensor_tx.sv
// Image-sensor style transmitter: FOT, H_ACTIVE-pixel lines separated by ROT
// gaps, then VBLK, repeating while enable is high. All outputs are registered
// from the next-state decode. frame_done marks the last pixel of a frame.
// Build option: DAQ_SENSOR_TX_LFSR_EN selects the LFSR pixel pattern.
module daq_sensor_tx
  import daq_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int FOT_CYC  = 16,
  parameter int ROT_CYC  = 8,
  parameter int VBLK_CYC = 32
) (
  input  logic       daq_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  output logic [7:0] data_out,
  output logic       frame_vaild,
  output logic       line_vaild,
  output logic [2:0] state,
  output logic       frame_done,
  output logic       busy
);

  localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(V_ACTIVE - 1);
  localparam logic [15:0]      FOT_LAST  = 16'(FOT_CYC - 1);
  localparam logic [15:0]      ROT_LAST  = 16'(ROT_CYC - 1);
  localparam logic [15:0]      VBLK_LAST = 16'(VBLK_CYC - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FOT  = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_ROT  = 3'd3;
  localparam logic [2:0] S_VBLK = 3'd4;

  logic [2:0]       fsm_q, fsm_d;
  logic [15:0]      ovh_q, ovh_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             frame_start;

  logic       frame_vaild_q, frame_vaild_d;
  logic       line_vaild_q, line_vaild_d;
  logic [2:0] state_q, state_d;
  logic       frame_done_q, frame_done_d;
  logic       busy_q, busy_d;

  // Phase sequencing and counter updates
  always_comb begin
    fsm_d       = fsm_q;
    ovh_d       = ovh_q;
    col_d       = col_q;
    row_d       = row_q;
    frame_cnt_d = frame_cnt_q;
    frame_start = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (enable) begin
          fsm_d       = S_FOT;
          ovh_d       = '0;
          frame_start = 1'b1;
        end
      end
      S_FOT: begin
        if (ovh_q == FOT_LAST) begin
          fsm_d = S_WR;
          ovh_d = '0;
          row_d = '0;
          col_d = '0;
        end else begin
          ovh_d = ovh_q + 16'd1;
        end
      end
      S_WR: begin
        if (col_q == COL_LAST) begin
          ovh_d = '0;
          if (row_q == ROW_LAST) begin
            fsm_d       = S_VBLK;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            fsm_d = S_ROT;
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      S_ROT: begin
        if (ovh_q == ROT_LAST) begin
          fsm_d = S_WR;
          ovh_d = '0;
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end else begin
          ovh_d = ovh_q + 16'd1;
        end
      end
      S_VBLK: begin
        if (ovh_q == VBLK_LAST) begin
          ovh_d = '0;
          // enable is only consulted here, so a frame in flight always completes
          if (enable) begin
            fsm_d       = S_FOT;
            frame_start = 1'b1;
          end else begin
            fsm_d = S_IDLE;
          end
        end else begin
          ovh_d = ovh_q + 16'd1;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Output decode from the next phase so the registered outputs track fsm_q
  always_comb begin
    frame_vaild_d = (fsm_d == S_FOT) || (fsm_d == S_WR) || (fsm_d == S_ROT);
    line_vaild_d  = (fsm_d == S_WR);
    busy_d        = (fsm_d != S_IDLE);
    frame_done_d  = (fsm_d == S_WR) && (col_d == COL_LAST) && (row_d == ROW_LAST);
    case (fsm_d)
      S_FOT:   state_d = ST_FOT;
      S_WR:    state_d = ST_WR_EN;
      S_ROT:   state_d = ST_ROT;
      default: state_d = ST_NONE;
    endcase
  end

  // Control, counter and output registers
  always_ff @(posedge daq_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fsm_q         <= S_IDLE;
      ovh_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      frame_cnt_q   <= '0;
      frame_vaild_q <= 1'b0;
      line_vaild_q  <= 1'b0;
      state_q       <= ST_NONE;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      ovh_q         <= ovh_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_vaild_q <= frame_vaild_d;
      line_vaild_q  <= line_vaild_d;
      state_q       <= state_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  daq_sensor_tx_pattern #(
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_pattern (
    .daq_clk     (daq_clk),
    .sys_rst_n   (sys_rst_n),
    .frame_start (frame_start),
    .line_vld    (line_vaild_d),
    .row         (row_d),
    .col         (col_d),
    .frame_cnt   (frame_cnt_d),
    .pixel       (data_out)
  );

  assign frame_vaild = frame_vaild_q;
  assign line_vaild  = line_vaild_q;
  assign state       = state_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_daq_sensor_tx.sv
// Bench for daq_sensor_tx with a small geometry (4x2, FOT 3, ROT 2, VBLK 5).
// A frame-level reference model expands each frame into its expected
// per-cycle outputs; the bench compares them one cycle at a time.
module tb_daq_sensor_tx;

  localparam int H   = 4;
  localparam int V   = 2;
  localparam int FOT = 3;
  localparam int ROT = 2;
  localparam int VB  = 5;
  localparam int FRAME_LEN = FOT + V * H + (V - 1) * ROT + VB;

  logic       daq_clk;
  logic       sys_rst_n;
  logic       enable;
  logic [7:0] data_out;
  logic       frame_vaild;
  logic       line_vaild;
  logic [2:0] state;
  logic       frame_done;
  logic       busy;

  typedef struct packed {
    logic       fv;
    logic       lv;
    logic [2:0] st;
    logic [7:0] d;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  daq_sensor_tx #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .FOT_CYC  (FOT),
    .ROT_CYC  (ROT),
    .VBLK_CYC (VB)
  ) dut (
    .daq_clk     (daq_clk),
    .sys_rst_n   (sys_rst_n),
    .enable      (enable),
    .data_out    (data_out),
    .frame_vaild (frame_vaild),
    .line_vaild  (line_vaild),
    .state       (state),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  initial daq_clk = 1'b0;
  always #5 daq_clk = ~daq_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx, input exp_t e);
    chk({ctx, ".data_out"},    data_out,           e.d);
    chk({ctx, ".frame_vaild"}, {7'd0, frame_vaild}, {7'd0, e.fv});
    chk({ctx, ".line_vaild"},  {7'd0, line_vaild},  {7'd0, e.lv});
    chk({ctx, ".state"},       {5'd0, state},       {5'd0, e.st});
    chk({ctx, ".frame_done"},  {7'd0, frame_done},  {7'd0, e.done});
    chk({ctx, ".busy"},        {7'd0, busy},        {7'd0, e.busy});
  endtask

  // Reference: one frame is FOT, lines with ROT gaps between them, then VBLK
  task automatic push_frame(input logic [7:0] fc);
    exp_t       e;
    logic [7:0] lfsr;
    lfsr = 8'hA5;
    for (int i = 0; i < FOT; i++) begin
      e = '{fv: 1'b1, lv: 1'b0, st: 3'b001, d: 8'h00, done: 1'b0, busy: 1'b1};
      q.push_back(e);
    end
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
`ifdef DAQ_SENSOR_TX_LFSR_EN
        e.d  = lfsr;
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`else
        e.d  = 8'((int'(fc) + r + c) % 256);
`endif
        e.fv = 1'b1; e.lv = 1'b1; e.st = 3'b010; e.busy = 1'b1;
        e.done = (r == V - 1) && (c == H - 1);
        q.push_back(e);
      end
      if (r < V - 1) begin
        for (int i = 0; i < ROT; i++) begin
          e = '{fv: 1'b1, lv: 1'b0, st: 3'b100, d: 8'h00, done: 1'b0, busy: 1'b1};
          q.push_back(e);
        end
      end
    end
    for (int i = 0; i < VB; i++) begin
      e = '{fv: 1'b0, lv: 1'b0, st: 3'b000, d: 8'h00, done: 1'b0, busy: 1'b1};
      q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back('0);
  endtask

  task automatic run_cycles(input string ctx, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge daq_clk);
      #1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s.model_empty observed=%0d expected=%0d", ctx, 0, 1);
      end else begin
        e = q.pop_front();
        check_outputs(ctx, e);
      end
    end
  endtask

  initial begin
    int n_idle;
    int k_drop;
    int j_col;

    sys_rst_n = 1'b0;
    enable    = 1'b0;

    // Reset state, before and after clock edges
    #1;
    check_outputs("reset0", '0);
    repeat (2) @(posedge daq_clk);
    #1;
    check_outputs("reset1", '0);

    // Release with enable low: stays idle
    @(negedge daq_clk);
    sys_rst_n = 1'b1;
    n_idle = $urandom_range(2, 6);
    push_idle(n_idle);
    run_cycles("idle", n_idle);

    // Continuous frames, long enough for frame_cnt to wrap past 255
    enable = 1'b1;
    for (int f = 0; f < 257; f++) begin
      push_frame(8'(f));
      run_cycles("frame", FRAME_LEN);
    end

    // Drop enable part way through a frame: frame and VBLK still complete
    k_drop = $urandom_range(1, FRAME_LEN - 1);
    push_frame(8'd1);
    run_cycles("drop_pre", k_drop);
    enable = 1'b0;
    run_cycles("drop_post", FRAME_LEN - k_drop);
    push_idle(6);
    run_cycles("drop_idle", 6);

    // Asynchronous reset in the middle of the second line
    enable = 1'b1;
    push_frame(8'd2);
    j_col = $urandom_range(0, H - 1);
    run_cycles("pre_rst", FOT + H + ROT + 1 + j_col);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_outputs("async_rst", '0);
    q.delete();
    repeat (2) @(posedge daq_clk);
    #1;
    check_outputs("rst_hold", '0);

    // Restart: frame counter starts again from zero
    @(negedge daq_clk);
    sys_rst_n = 1'b1;
    push_frame(8'd0);
    push_frame(8'd1);
    run_cycles("restart", FRAME_LEN + 3);
    enable = 1'b0;
    run_cycles("restart", FRAME_LEN - 3);
    push_idle(4);
    run_cycles("final_idle", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/daq_sensor_tx.md
DAQ_SENSOR_TX -- requirements
Module: daq_sensor_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: pixels per line (≥1).
REQ-002 SHALL have parameter V_ACTIVE, default 480: lines per frame (≥1).
REQ-003 SHALL have parameter FOT_CYC, default 16: frame-overhead cycles before the first line (≥1).
REQ-004 SHALL have parameter ROT_CYC, default 8: row-overhead cycles between lines (≥1).
REQ-005 SHALL have parameter VBLK_CYC, default 32: inter-frame cycles with frame_vaild low (≥1).
REQ-006 SHALL have port daq_clk  input  1  pixel clock; all logic on its rising edge.
REQ-007 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port enable  input  1  level; run frames while high.
REQ-009 SHALL have port data_out  output  8  pixel data.
REQ-010 SHALL have port frame_vaild  output  1  frame-valid strobe.
REQ-011 SHALL have port line_vaild  output  1  line-valid strobe.
REQ-012 SHALL have port state  output  3  one-hot phase: FOT=001, WR_EN=010, ROT=100, else 000.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at end of last line.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, FOT, WR_EN, ROT, VBLK; all outputs registered.
REQ-016 IDLE: frame_vaild=0, line_vaild=0, data_out=0, state=000; enable sampled high -> FOT next cycle.
REQ-017 FOT: frame_vaild=1, line_vaild=0, state=001, exactly FOT_CYC cycles, then WR_EN with row=0.
REQ-018 WR_EN: frame_vaild=1, line_vaild=1, state=010, exactly H_ACTIVE cycles, one pixel per cycle, col 0..H_ACTIVE-1.
REQ-019 End of WR_EN with row<V_ACTIVE-1 -> ROT; with row=V_ACTIVE-1 -> VBLK and frame_done=1 for that single transition cycle.
REQ-020 ROT: frame_vaild=1, line_vaild=0, state=100, exactly ROT_CYC cycles, then WR_EN with row+1.
REQ-021 VBLK: frame_vaild=0, line_vaild=0, state=000, exactly VBLK_CYC cycles; then FOT if enable=1, else IDLE.
REQ-022 enable deasserted mid-frame SHALL NOT truncate the frame; current frame and its VBLK complete before IDLE.
REQ-023 Default pattern: data_out = (frame_cnt + row + col) mod 256 during WR_EN; 0 outside WR_EN.
REQ-024 frame_cnt 8-bit, increments on each VBLK entry, wraps 255->0; col/row counters sized $clog2 of their limit; overhead counter 16-bit.
REQ-025 H_ACTIVE=1 or V_ACTIVE=1 SHALL be legal (single-pixel lines, no ROT respectively).

Reset
REQ-026 sys_rst_n low SHALL asynchronously force IDLE, all counters 0, data_out=0, frame_vaild=0, line_vaild=0, state=000, frame_done=0, busy=0, including mid-line.
REQ-027 After release, first FOT SHALL begin the cycle after enable is first sampled high.

Configuration
REQ-028 Macro DAQ_SENSOR_TX_LFSR_EN defined: data_out in WR_EN SHALL be an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded 8'hA5 at each FOT entry, advanced once per WR_EN cycle, first pixel = seed.
REQ-029 Macro undefined: ramp pattern of REQ-023; no LFSR logic synthesised.

Structure
REQ-030 State encodings FOT/WR_EN/ROT (3'b001/010/100) and LFSR seed/taps SHALL live in shared package daq_pkg, also used by the receiver.
REQ-031 Pixel pattern logic SHALL be sub-module daq_sensor_tx_pattern (inputs: frame/line/pixel strobes, row, col, frame_cnt; output: 8-bit pixel).

Verification (H_ACTIVE=4, V_ACTIVE=2, FOT_CYC=3, ROT_CYC=2, VBLK_CYC=5)
REQ-032 enable=1 continuous -> frame period 18 cycles; state sequence 001x3, 010x4, 100x2, 010x4, 000x5; frame_done one pulse per frame.
REQ-033 Ramp, frame 0 -> row0 data 0,1,2,3; row1 1,2,3,4; frame 1 row0 1,2,3,4; after 256 frames pattern repeats.
REQ-034 enable dropped at cycle 5 of frame -> frame completes, VBLK 5 cycles, IDLE, busy=0, no further frame_vaild.
REQ-035 sys_rst_n pulsed low in second WR_EN -> all outputs 0 same cycle asynchronously; restart with enable gives frame_cnt=0 data 0,1,2,3.
REQ-036 DAQ_SENSOR_TX_LFSR_EN defined -> first pixel of every frame 8'hA5, subsequent pixels match reference LFSR; loopback into receiver captures identical 8 bytes per frame.
